acc_seq_core: RTL and testbench

- Parametrised accumulator datapath with its own sequencer.
- Replaces the fixed-op, fixed-operand accumulator/ALU pairing and its separate clock-gen stage.
- Runs N iterations of a selectable ALU op, acc <= acc OP operand, at a programmable tick rate, with a start/done handshake.
- Single clock domain: rate control is a clock-enable prescaler, not a derived clock; out_strobe replaces the old inverted accumulator clock as the output qualifier.

---
 rtl/acc_seq_pkg.sv | 19 +
 rtl/acc_alu.sv | 51 +++++
 rtl/acc_seq_core.sv | 115 +++++++++++
 tb/tb_acc_seq_core.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_seq_pkg.sv
// acc_seq shared definitions: ALU op codes and sequencer states.
package acc_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/acc_alu.sv
// Combinational accumulator ALU, W bits wide.
// ACC_SEQ_SAT_EN makes ADD/SUB saturate instead of wrapping.
module acc_alu
  import acc_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic         cout
);

  logic [W:0] sum;
  logic [W:0] dif;

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};

  always_comb begin
    res  = '0;
    cout = 1'b0;
    unique case (op)
      OP_ADD: begin
        res  = sum[W-1:0];
        cout = sum[W];
`ifdef ACC_SEQ_SAT_EN
        if (sum[W]) res = '1;
`endif
      end
      OP_SUB: begin
        res  = dif[W-1:0];
        cout = dif[W];
`ifdef ACC_SEQ_SAT_EN
        if (dif[W]) res = '0;
`endif
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SHL: begin
        res  = {a[W-2:0], 1'b0};
        cout = a[W-1];
      end
      OP_SHR:  res = {1'b0, a[W-1:1]};
      OP_PASS: res = b;
    endcase
  end

endmodule

// File: rtl/acc_seq_core.sv
// Sequenced accumulator: N ticks of acc <= acc OP operand.
// Optional ADD/SUB saturation via ACC_SEQ_SAT_EN.
module acc_seq_core
  import acc_seq_pkg::*;
#(
  parameter int W   = 8,
  parameter int CW  = 8,
  parameter int DIV = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          acc_clr,
  input  logic [2:0]    op,
  input  logic [W-1:0]  operand,
  input  logic [CW-1:0] iter,
  output logic          busy,
  output logic          done,
  output logic          out_strobe,
  output logic [W-1:0]  acc_out,
  output logic          carry
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  state_t        state;
  state_t        state_nx;
  logic [2:0]    op_q;
  logic [W-1:0]  opnd_q;
  logic [CW-1:0] rem;
  logic [PW-1:0] pre;
  logic          accept;
  logic          tick;
  logic [W-1:0]  alu_res;
  logic          alu_cout;

  assign tick = (state == S_RUN) && (pre == PMAX);

  acc_alu #(.W(W)) u_alu (
    .op   (op_q),
    .a    (acc_out),
    .b    (opnd_q),
    .res  (alu_res),
    .cout (alu_cout)
  );

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = (iter != '0) ? S_RUN : S_FIN;
        end
      end
      S_RUN: begin
        if (tick && rem == CW'(1)) state_nx = S_FIN;
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      opnd_q     <= '0;
      rem        <= '0;
      pre        <= '0;
      acc_out    <= '0;
      carry      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_strobe <= 1'b0;
    end else begin
      done       <= 1'b0;
      out_strobe <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (acc_clr) acc_out <= '0;
          if (accept) begin
            op_q   <= op;
            opnd_q <= operand;
            rem    <= iter;
            carry  <= 1'b0;
            pre    <= '0;
            busy   <= 1'b1;
          end
        end
        S_RUN: begin
          pre <= tick ? '0 : pre + PW'(1);
          if (tick) begin
            acc_out    <= alu_res;
            carry      <= carry | alu_cout;
            out_strobe <= 1'b1;
            rem        <= rem - CW'(1);
          end
        end
        S_FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_seq_core.sv
// Self-checking bench for acc_seq_core (DIV=1 and DIV=4 instances).
module tb_acc_seq_core;
  import acc_seq_pkg::*;

`ifdef ACC_SEQ_SAT_EN
  localparam logic [7:0] X_ADD = 8'hFF;
  localparam logic [7:0] X_SUB = 8'h00;
  localparam logic [7:0] X_INC = 8'hFF;
`else
  localparam logic [7:0] X_ADD = 8'h04;
  localparam logic [7:0] X_SUB = 8'hFE;
  localparam logic [7:0] X_INC = 8'h00;
`endif

  typedef struct {
    logic       clr;
    logic [2:0] op;
    logic [7:0] b;
    logic [7:0] n;
    logic [7:0] acc;
    logic       c;
  } vec_t;

  typedef struct {
    logic [7:0] acc;
    int         at;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0, clr1 = 1'b0;
  logic       start4 = 1'b0, clr4 = 1'b0;
  logic [2:0] op = '0;
  logic [7:0] operand = '0;
  logic [7:0] iter = '0;
  logic       b1, d1, s1, c1;
  logic       b4, d4, s4, c4;
  logic [7:0] a1, a4;

  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  bit   mon_en = 1'b1;
  logic [7:0] mdl [2];
  exp_t q1[$];
  exp_t q4[$];
  vec_t tbl[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  acc_seq_core #(.W(8), .CW(8), .DIV(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .acc_clr(clr1),
    .op(op), .operand(operand), .iter(iter),
    .busy(b1), .done(d1), .out_strobe(s1),
    .acc_out(a1), .carry(c1)
  );

  acc_seq_core #(.W(8), .CW(8), .DIV(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .acc_clr(clr4),
    .op(op), .operand(operand), .iter(iter),
    .busy(b4), .done(d4), .out_strobe(s4),
    .acc_out(a4), .carry(c4)
  );

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] model(
    input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    int r;
    case (o)
      OP_ADD: begin
        r = int'(a) + int'(b);
`ifdef ACC_SEQ_SAT_EN
        if (r > 255) r = 255;
`endif
      end
      OP_SUB: begin
        r = int'(a) - int'(b);
`ifdef ACC_SEQ_SAT_EN
        if (r < 0) r = 0;
`else
        if (r < 0) r = r + 256;
`endif
      end
      OP_AND: r = int'(a & b);
      OP_OR:  r = int'(a | b);
      OP_XOR: r = int'(a ^ b);
      OP_SHL: r = (int'(a) * 2) % 256;
      OP_SHR: r = int'(a) / 2;
      default: r = int'(b);
    endcase
    return r[7:0];
  endfunction

  function automatic vec_t mk(
    input logic cl, input logic [2:0] o, input logic [7:0] b,
    input logic [7:0] n, input logic [7:0] x, input logic c);
    vec_t v;
    v.clr = cl; v.op = o; v.b = b; v.n = n; v.acc = x; v.c = c;
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst) begin
      if (s1) begin
        if (q1.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL strobe1: unexpected at edge %0d acc=%0d", cyc, a1);
        end else begin
          e = q1.pop_front();
          chk("strobe1 acc", int'(a1), int'(e.acc));
          chk("strobe1 edge", cyc, e.at);
        end
      end
      if (s4) begin
        if (q4.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL strobe4: unexpected at edge %0d acc=%0d", cyc, a4);
        end else begin
          e = q4.pop_front();
          chk("strobe4 acc", int'(a4), int'(e.acc));
          chk("strobe4 edge", cyc, e.at);
        end
      end
    end
  end

  task automatic run(
    input int sel, input logic cl, input logic [2:0] o,
    input logic [7:0] b, input logic [7:0] n,
    input logic [7:0] xacc, input logic xc,
    input bit poke, input string nm);
    int k, dv, dat;
    bit got, bb;
    logic [7:0] m;
    exp_t e;
    @(negedge clk);
    dv = (sel != 0) ? 4 : 1;
    k  = cyc + 1;
    op = o; operand = b; iter = n;
    if (sel != 0) begin start4 = 1'b1; clr4 = cl; end
    else          begin start1 = 1'b1; clr1 = cl; end
    m = mdl[sel];
    if (cl) m = '0;
    for (int i = 1; i <= int'(n); i++) begin
      m = model(o, m, b);
      e.acc = m;
      e.at  = k + i * dv;
      if (sel != 0) q4.push_back(e);
      else          q1.push_back(e);
    end
    mdl[sel] = m;
    got = 1'b0; bb = 1'b0; dat = -1;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      start1 = 1'b0; clr1 = 1'b0;
      start4 = 1'b0; clr4 = 1'b0;
      if (poke && t == 1) begin
        if (sel != 0) begin start4 = 1'b1; clr4 = 1'b1; end
        else          begin start1 = 1'b1; clr1 = 1'b1; end
      end
      if ((sel != 0) ? d4 : d1) begin
        got = 1'b1;
        dat = cyc;
      end else if (!((sel != 0) ? b4 : b1)) begin
        bb = 1'b1;
      end
    end
    chk({nm, " done edge"}, dat, k + int'(n) * dv + 1);
    chk({nm, " busy held"}, int'(bb), 0);
    chk({nm, " busy at done"}, int'((sel != 0) ? b4 : b1), 0);
    chk({nm, " acc"}, int'((sel != 0) ? a4 : a1), int'(xacc));
    chk({nm, " carry"}, int'((sel != 0) ? c4 : c1), int'(xc));
    chk({nm, " strobes left"},
        (sel != 0) ? q4.size() : q1.size(), 0);
  endtask

  initial begin
    bit saw;
    mdl[0] = '0; mdl[1] = '0;
    tbl.push_back(mk(1'b1, OP_ADD,  8'd2,   8'd5, 8'd10,  1'b0));
    tbl.push_back(mk(1'b0, OP_PASS, 8'd250, 8'd1, 8'd250, 1'b0));
    tbl.push_back(mk(1'b0, OP_ADD,  8'd9,   8'd0, 8'd250, 1'b0));
    tbl.push_back(mk(1'b0, OP_ADD,  8'd5,   8'd2, X_ADD,  1'b1));
    tbl.push_back(mk(1'b0, OP_PASS, 8'd3,   8'd1, 8'd3,   1'b0));
    tbl.push_back(mk(1'b0, OP_SUB,  8'd5,   8'd1, X_SUB,  1'b1));
    tbl.push_back(mk(1'b0, OP_PASS, 8'd77,  8'd1, 8'd77,  1'b0));
    tbl.push_back(mk(1'b1, OP_OR,   8'h0F,  8'd1, 8'h0F,  1'b0));
    tbl.push_back(mk(1'b0, OP_PASS, 8'h81,  8'd1, 8'h81,  1'b0));
    tbl.push_back(mk(1'b0, OP_SHL,  8'h00,  8'd1, 8'h02,  1'b1));
    tbl.push_back(mk(1'b0, OP_PASS, 8'h81,  8'd1, 8'h81,  1'b0));
    tbl.push_back(mk(1'b0, OP_SHR,  8'h00,  8'd1, 8'h40,  1'b0));
    tbl.push_back(mk(1'b0, OP_PASS, 8'h81,  8'd1, 8'h81,  1'b0));
    tbl.push_back(mk(1'b0, OP_XOR,  8'hFF,  8'd1, 8'h7E,  1'b0));
    tbl.push_back(mk(1'b0, OP_PASS, 8'h81,  8'd1, 8'h81,  1'b0));
    tbl.push_back(mk(1'b0, OP_AND,  8'h0F,  8'd1, 8'h01,  1'b0));
    tbl.push_back(mk(1'b0, OP_PASS, 8'h81,  8'd1, 8'h81,  1'b0));
    tbl.push_back(mk(1'b0, OP_SHL,  8'h00,  8'd3, 8'h08,  1'b1));
    tbl.push_back(mk(1'b0, OP_SUB,  8'd1,   8'd3, 8'd5,   1'b0));
    tbl.push_back(mk(1'b1, OP_ADD,  8'hFF,  8'd1, 8'hFF,  1'b0));
    tbl.push_back(mk(1'b0, OP_ADD,  8'd1,   8'd1, X_INC,  1'b1));

    repeat (3) @(negedge clk);
    chk("reset u1", int'({b1, d1, s1, c1, a1}), 0);
    chk("reset u4", int'({b4, d4, s4, c4, a4}), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++)
      run(0, tbl[i].clr, tbl[i].op, tbl[i].b, tbl[i].n,
          tbl[i].acc, tbl[i].c, 1'b0, $sformatf("vec%0d", i));

    run(0, 1'b0, OP_PASS, 8'd20, 8'd1, 8'd20, 1'b0, 1'b0, "pre poke");
    run(0, 1'b0, OP_ADD,  8'd3,  8'd4, 8'd32, 1'b0, 1'b1, "poke");

    run(1, 1'b1, OP_PASS, 8'd10, 8'd1, 8'd10, 1'b0, 1'b0, "div4 load");
    run(1, 1'b0, OP_SUB,  8'd1,  8'd3, 8'd7,  1'b0, 1'b0, "div4 sub");
    run(1, 1'b0, OP_ADD,  8'd9,  8'd0, 8'd7,  1'b0, 1'b0, "div4 zero");

    mon_en = 1'b0;
    @(negedge clk);
    op = OP_ADD; operand = 8'd1; iter = 8'd10; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort pre busy", int'(b1), 1);
    rst = 1'b1;
    #1;
    chk("abort acc", int'(a1), 0);
    chk("abort flags", int'({b1, d1, s1, c1}), 0);
    saw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (d1) saw = 1'b1;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (d1 || b1 || s1) saw = 1'b1;
    end
    chk("abort no done", int'(saw), 0);
    mdl[0] = '0; mdl[1] = '0;
    q1.delete(); q4.delete();
    mon_en = 1'b1;
    run(0, 1'b0, OP_ADD, 8'd7, 8'd1, 8'd7, 1'b0, 1'b0, "post rst");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
